// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_DRESP = 3'd2,
    S_FETCH = 3'd3,
    S_FRESP = 3'd4
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way alternating-priority selector: on contention the requester that
// did not win last time is granted.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  always_comb begin
    grant_valid = if_req | dm_req;
    grant       = GNT_FETCH;
    if (if_req && dm_req)
      grant = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    else if (dm_req)
      grant = GNT_DATA;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Request/grant sequencer sharing one 1-cycle-latency memory between fetch
// and load/store. Optional misaligned-data trap: MEM_ARB_MISALIGN_TRAP_EN.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_enable
);

  localparam bit DEPTH_OK = (DEPTH == (1 << (ADDR_W - 2)));

  state_t            state;
  grant_t            last_grant;
  logic              grant_valid;
  grant_t            grant;
  logic [ADDR_W-3:0] if_waddr_q;
  logic [ADDR_W-3:0] dm_waddr_q;
  logic              dm_we_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              misalign_q;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  logic unused_bits;
  assign unused_bits = ^{if_addr[1:0], DEPTH_OK};
`else
  logic unused_bits;
  assign unused_bits = ^{if_addr[1:0], dm_addr[1:0], DEPTH_OK};
  assign misalign_q  = 1'b0;
  assign dm_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= S_IDLE;
      last_grant <= GNT_DATA;
      if_waddr_q <= '0;
      dm_waddr_q <= '0;
      dm_we_q    <= 1'b0;
      dm_wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_rvalid  <= 1'b0;
      dm_done    <= 1'b0;
      pc_enable  <= 1'b0;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
      dm_err     <= 1'b0;
`endif
    end else begin
      if_rvalid <= 1'b0;
      dm_done   <= 1'b0;
      pc_enable <= 1'b0;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
      dm_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant;
            if (grant == GNT_DATA) begin
              dm_waddr_q <= dm_addr[ADDR_W-1:2];
              dm_we_q    <= dm_we;
              dm_wdata_q <= dm_wdata;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
              misalign_q <= |dm_addr[1:0];
`endif
              state      <= S_DATA;
            end else begin
              if_waddr_q <= if_addr[ADDR_W-1:2];
              state      <= S_FETCH;
            end
          end
        end
        // Pulses are registered on entry to the response state so they
        // line up with the memory's read data.
        S_DATA: begin
          dm_done <= 1'b1;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
          dm_err  <= misalign_q;
`endif
          state   <= S_DRESP;
        end
        S_DRESP: begin
          if (!dm_we_q && !misalign_q)
            dm_rdata_q <= mem_rdata;
          state <= S_IDLE;
        end
        S_FETCH: begin
          if_rvalid <= 1'b1;
          pc_enable <= 1'b1;
          state     <= S_FRESP;
        end
        S_FRESP: begin
          if_rdata_q <= mem_rdata;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data is live from memory during the response cycle, then held.
  assign dm_rdata = (state == S_DRESP && !dm_we_q && !misalign_q) ? mem_rdata : dm_rdata_q;
  assign if_rdata = (state == S_FRESP) ? mem_rdata : if_rdata_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_DATA: begin
        mem_en    = !misalign_q;
        mem_we    = dm_we_q && !misalign_q;
        mem_addr  = dm_waddr_q;
        mem_wdata = dm_wdata_q;
      end
      S_FETCH: begin
        mem_en   = 1'b1;
        mem_addr = if_waddr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed, table-driven bench for mem_access_arbiter with a behavioural
// 1-cycle-latency memory; honours MEM_ARB_MISALIGN_TRAP_EN.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [7:0]  dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        pc_enable;

  logic [31:0] mem [64];
  logic        mem_load = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .DEPTH(64)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_rvalid (if_rvalid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc_enable (pc_enable)
  );

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 1) ? 32'h0050_0093 : (32'hA000_0000 | 32'(i));
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    bit          fetch;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          exp_en;
    logic [5:0]  exp_maddr;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one access from S_IDLE and checks grant+1, grant+2, grant+3.
  task automatic do_txn(input vec_t v);
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    chk("mem_en", 32'(mem_en), 32'(v.exp_en));
    chk("mem_we", 32'(mem_we), 32'(v.exp_en && v.we && !v.fetch));
    if (v.exp_en) chk("mem_addr", 32'(mem_addr), 32'(v.exp_maddr));
    if (v.exp_en && v.we && !v.fetch) chk("mem_wdata", mem_wdata, v.wdata);
    chk("early_pulse", 32'({dm_done, if_rvalid, pc_enable}), 32'd0);
    tick();
    chk("dm_done", 32'(dm_done), 32'(!v.fetch));
    chk("if_rvalid", 32'(if_rvalid), 32'(v.fetch));
    chk("pc_enable", 32'(pc_enable), 32'(v.fetch));
    chk("dm_err", 32'(dm_err), 32'(v.exp_err));
    chk("resp_mem_en", 32'(mem_en), 32'd0);
    if (v.fetch)      chk("if_rdata", if_rdata, v.exp_rdata);
    else if (!v.we)   chk("dm_rdata", dm_rdata, v.exp_rdata);
    tick();
    chk("pulse_clear", 32'({dm_done, if_rvalid, pc_enable}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rv;
    int n_dd;
    vec_t v;

    vecs[0] = '{0, 1, 8'h08, 32'hDEAD_BEEF, 1, 6'd2,  32'h0,         0};
    vecs[1] = '{0, 0, 8'h08, 32'h0,         1, 6'd2,  32'hDEAD_BEEF, 0};
    vecs[2] = '{1, 0, 8'h04, 32'h0,         1, 6'd1,  32'h0050_0093, 0};
    vecs[3] = '{0, 0, 8'h0C, 32'h0,         1, 6'd3,  32'hA000_0003, 0};
    vecs[4] = '{0, 1, 8'hFC, 32'h1234_5678, 1, 6'd63, 32'h0,         0};
    vecs[5] = '{0, 0, 8'hFC, 32'h0,         1, 6'd63, 32'h1234_5678, 0};
    vecs[6] = '{1, 0, 8'hFC, 32'h0,         1, 6'd63, 32'h1234_5678, 0};
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    vecs[7] = '{0, 0, 8'h06, 32'h0,         0, 6'd0,  32'h1234_5678, 1};
`else
    vecs[7] = '{0, 0, 8'h06, 32'h0,         1, 6'd1,  32'h0050_0093, 0};
`endif
    vecs[8] = '{1, 0, 8'h07, 32'h0,         1, 6'd1,  32'h0050_0093, 0};
    vecs[9] = '{1, 0, 8'h00, 32'h0,         1, 6'd0,  32'hA000_0000, 0};

    // Reset state
    tick();
    tick();
    mem_load = 1'b0;
    chk("rst_mem", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_pulses", 32'({dm_done, if_rvalid, pc_enable, dm_err}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    nRst = 1'b1;

    // Contention straight out of reset: fetch first, then alternate
    if_req = 1'b1; if_addr = 8'h00;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h0C;
    n_rv = 0; n_dd = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("alt_rvalid_c%0d", c), 32'(if_rvalid), 32'(c == 2 || c == 8));
      chk($sformatf("alt_done_c%0d", c), 32'(dm_done), 32'(c == 5 || c == 11));
      chk($sformatf("alt_pc_c%0d", c), 32'(pc_enable), 32'(c == 2 || c == 8));
      if (if_rvalid) n_rv++;
      if (dm_done) n_dd++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("alt_rvalid_count", 32'(n_rv), 32'd2);
    chk("alt_done_count", 32'(n_dd), 32'd2);
    chk("alt_if_rdata", if_rdata, 32'hA000_0000);
    chk("alt_dm_rdata", dm_rdata, 32'hA000_0003);
    tick();

    // Directed single-access table
    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Address change after grant is ignored
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h08;
    tick();
    dm_addr = 8'h10; dm_req = 1'b0;
    chk("late_addr_mem_addr", 32'(mem_addr), 32'd2);
    tick();
    chk("late_addr_done", 32'(dm_done), 32'd1);
    chk("late_addr_rdata", dm_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset in the middle of a store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 32'hBAD0_BAD0;
    tick();
    dm_req = 1'b0;
    chk("mid_rst_pre_en", 32'({mem_en, mem_we}), 32'd3);
    nRst = 1'b0;
    #1;
    chk("mid_rst_en", 32'({mem_en, mem_we}), 32'd0);
    chk("mid_rst_rdata", dm_rdata, 32'd0);
    tick();
    nRst = 1'b1;
    tick();
    chk("post_rst_outs", 32'({mem_en, mem_we, dm_done, if_rvalid, pc_enable}), 32'd0);
    chk("post_rst_mem4", mem[4], 32'hA000_0004);
    v = '{0, 0, 8'h10, 32'h0, 1, 6'd4, 32'hA000_0004, 0};
    do_txn(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Sequences and shares the single-port, 1-cycle-read-latency instruction/data memory between the instruction-fetch requester and the load/store requester of the single-cycle core. It replaces ad-hoc stall logic with an explicit request/grant FSM. It drives the memory port and a pc_enable stall strobe to the PC register.

Parameters:
ADDR_W, 8, byte-address width of both requesters; memory word address = addr[ADDR_W-1:2]
DATA_W, 32, data word width
DEPTH, 64, memory depth in words; must equal 2**(ADDR_W-2)

Ports:
clk  in  1  clock
nRst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request, level, held until if_rvalid
if_addr  in  ADDR_W  fetch byte address
if_rdata  out  DATA_W  fetched instruction, registered, held until next fetch completes
if_rvalid  out  1  one-cycle pulse, if_rdata valid
dm_req  in  1  data request, level, held until dm_done
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data byte address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, registered, held until next load completes
dm_done  out  1  one-cycle pulse, data access complete
dm_err  out  1  misaligned-access flag, valid with dm_done
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W-2  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0
pc_enable  out  1  one-cycle pulse permitting the PC to advance

Behaviour:
- Reset, asynchronous: state S_IDLE, last_grant=GNT_DATA, if_rdata=0, dm_rdata=0, latched request fields=0.
- All pulses and mem_* outputs are 0 in reset.
- mem_en, mem_we, mem_addr and mem_wdata decode combinationally from state plus latched fields, so reset mid-access drops mem_en immediately.
- S_IDLE, arbitration:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant the requester not equal to last_grant (alternation, no starvation).
  - Neither: stay in S_IDLE.
  - On grant, latch the address (plus dm_we and dm_wdata for data), update last_grant, and go to S_DATA or S_FETCH.
- S_DATA:
  - mem_en=1, mem_we=dm_we_q, mem_addr=dm_addr_q[ADDR_W-1:2], mem_wdata=dm_wdata_q.
  - Next state S_DRESP.
- S_DRESP:
  - Load: dm_rdata<=mem_rdata.
  - dm_done=1 for loads and stores.
  - Next state S_IDLE.
- S_FETCH:
  - mem_en=1, mem_we=0, mem_addr=if_addr_q[ADDR_W-1:2].
  - Next state S_FRESP.
- S_FRESP:
  - if_rdata<=mem_rdata, if_rvalid=1, pc_enable=1.
  - Next state S_IDLE.
- Latency: request sampled in S_IDLE at cycle N, mem_en at N+1, completion pulse at N+2. One access per 3 cycles; the next grant can occur at N+3.
- Inputs are sampled only at grant. Address or data changes after grant are ignored. A request dropped after grant still completes, and its pulse is still issued.
- dm_addr[1:0] and if_addr[1:0] are ignored (word access only) unless the macro below is defined.
- pc_enable is never asserted outside S_FRESP. Data accesses never advance the PC.
- Unreachable state encodings return to S_IDLE.

Optional Feature:
MEM_ARB_MISALIGN_TRAP_EN
- Defined: a data grant with dm_addr_q[1:0]!=0 goes S_DATA to S_DRESP with mem_en=0 (no memory op), dm_done=1, dm_err=1, and dm_rdata unchanged.
- Undefined: dm_err is tied 0 and low address bits are truncated.

Decomposition:
- Package mem_arb_pkg:
  - state enum: S_IDLE, S_DATA, S_DRESP, S_FETCH, S_FRESP.
  - grant enum: GNT_FETCH, GNT_DATA.
  - ADDR_W/DATA_W defaults.
- Sub-module mem_arb_pick: combinational 2-way alternating-priority selector; inputs if_req, dm_req, last_grant; outputs grant_valid, grant.

Test Plan:
- Store dm_addr=0x08, dm_wdata=0xDEADBEEF, then load 0x08 -> mem_we=1 with mem_addr=2 one cycle; load gives dm_done with dm_rdata=0xDEADBEEF 2 cycles after grant.
- Fetch only, if_addr=0x04, memory word1=0x00500093 -> mem_en at N+1 with mem_addr=1; at N+2 if_rvalid=1, pc_enable=1, if_rdata=0x00500093.
- if_req and dm_req held together for 12 cycles after reset -> grants alternate FETCH, DATA, FETCH, DATA (first is fetch since last_grant resets to DATA); exactly 2 if_rvalid and 2 dm_done.
- nRst asserted in S_DATA with a store pending -> mem_en/mem_we drop the same cycle, no write; after release: S_IDLE, outputs 0, memory unchanged.
- Change dm_addr 0x08 to 0x10 one cycle after grant -> access uses word 2 only.
- With MEM_ARB_MISALIGN_TRAP_EN, load dm_addr=0x06 -> no mem_en, dm_done=1 with dm_err=1, dm_rdata unchanged; without the macro -> reads word 1, dm_err=0.
